// File: rtl/mem_stage_dm.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_dm
// Description : MIPS M stage. Holds the word-organised data memory with byte
//               and halfword merging, the load extension, and the M->W register.
// Revision    : 1.0
// ============================================================================
module mem_stage_dm #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_m,
    input  logic [31:0] aluout_m,
    input  logic [31:0] rt_m,
    input  logic [31:0] pc4_m,
    input  logic [31:0] pc8_m,
    output logic [31:0] ir_w,
    output logic [31:0] aluout_w,
    output logic [31:0] dmout_w,
    output logic [31:0] pc4_w,
    output logic [31:0] pc8_w,
    output logic        misalign_w
);

    localparam int         c_DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [5:0] c_OP_LB  = 6'h20;
    localparam logic [5:0] c_OP_LH  = 6'h21;
    localparam logic [5:0] c_OP_LW  = 6'h23;
    localparam logic [5:0] c_OP_LBU = 6'h24;
    localparam logic [5:0] c_OP_LHU = 6'h25;
    localparam logic [5:0] c_OP_SB  = 6'h28;
    localparam logic [5:0] c_OP_SH  = 6'h29;
    localparam logic [5:0] c_OP_SW  = 6'h2b;

    logic [3:0][7:0] r_mem [c_DEPTH];

    logic [5:0]            w_op;
    logic [1:0]            w_off;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_word;
    logic                  w_is_half;
    logic                  w_signed;
    logic                  w_misalign;
    logic [3:0]            w_be;
    logic [3:0][7:0]       w_wdata;
    logic [31:0]           w_rword;
    logic [15:0]           w_half;
    logic [7:0]            w_byte;
    logic [31:0]           w_dmout;

    assign w_op    = ir_m[31:26];
    assign w_off   = aluout_m[1:0];
    assign w_idx   = aluout_m[DEPTH_LOG2+1:2];
    assign w_rword = r_mem[w_idx];

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_word  = 1'b0;
        w_is_half  = 1'b0;
        w_signed   = 1'b0;
        case (w_op)
            c_OP_LW:  begin w_is_load  = 1'b1; w_is_word = 1'b1; end
            c_OP_LH:  begin w_is_load  = 1'b1; w_is_half = 1'b1; w_signed = 1'b1; end
            c_OP_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
            c_OP_LB:  begin w_is_load  = 1'b1; w_signed  = 1'b1; end
            c_OP_LBU: begin w_is_load  = 1'b1; end
            c_OP_SW:  begin w_is_store = 1'b1; w_is_word = 1'b1; end
            c_OP_SH:  begin w_is_store = 1'b1; w_is_half = 1'b1; end
            c_OP_SB:  begin w_is_store = 1'b1; end
            default:  ;
        endcase
    end

    // Byte accesses can never be misaligned; only word and halfword forms check.
    assign w_misalign = (w_is_load || w_is_store) &&
                        ((w_is_word && (w_off != 2'b00)) || (w_is_half && w_off[0]));

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = rt_m;
        if (w_is_store && !w_misalign) begin
            if (w_is_word) begin
                w_be = 4'b1111;
            end else if (w_is_half) begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rt_m[15:0]}};
            end else begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{rt_m[7:0]}};
            end
        end
    end

    assign w_half = w_off[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        case (w_off)
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
    end

    always_comb begin
        w_dmout = 32'h0;
        if (w_is_load && !w_misalign) begin
            if (w_is_word)
                w_dmout = w_rword;
            else if (w_is_half)
                w_dmout = {{16{w_signed & w_half[15]}}, w_half};
            else
                w_dmout = {{24{w_signed & w_byte[7]}}, w_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (w_be[b])
                    r_mem[w_idx][b] <= w_wdata[b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_w       <= 32'h0;
            aluout_w   <= 32'h0;
            dmout_w    <= 32'h0;
            pc4_w      <= 32'h0;
            pc8_w      <= 32'h0;
            misalign_w <= 1'b0;
        end else begin
            ir_w       <= ir_m;
            aluout_w   <= aluout_m;
            dmout_w    <= w_dmout;
            pc4_w      <= pc4_m;
            pc8_w      <= pc8_m;
            misalign_w <= w_misalign;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_dm.md
# mem_stage_dm

Memory-stage block for the five-stage MIPS pipeline. It consumes the E→M pipeline register outputs, performs the data-memory access for the instruction in M, and latches the M→W pipeline register. It contains a word-organised data memory with byte and halfword store merging, load-extension logic for lb/lbu/lh/lhu/lw, and misalignment suppression. Its registered outputs feed the writeback mux and the forwarding unit.

## Interface
- DEPTH_LOG2, 10, log2 of data-memory depth in 32-bit words (default 1024 words = 4 KiB)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clock clk
- ir_m  in  32  instruction in M stage
- aluout_m  in  32  effective address, or ALU result for non-memory instructions
- rt_m  in  32  forwarded rt value; store data
- pc4_m  in  32  PC+4 of the instruction in M
- pc8_m  in  32  PC+8 of the instruction in M; link value
- ir_w  out  32  registered ir_m
- aluout_w  out  32  registered aluout_m
- dmout_w  out  32  registered, extended load data; 0 for non-loads
- pc4_w  out  32  registered pc4_m
- pc8_w  out  32  registered pc8_m
- misalign_w  out  1  registered; 1 if the M instruction was a misaligned load or store

## Operation
- Decode uses opcode ir_m[31:26]: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2b, sh 0x29, sb 0x28. All other opcodes are non-memory.
- Word index is aluout_m[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2 bytes.
- Byte offset is aluout_m[1:0]. Byte ordering is little-endian: offset 0 maps to bits [7:0].
- Store merging:
  - sw writes the full word.
  - sh writes rt_m[15:0] into halfword aluout_m[1]; the other halfword is preserved.
  - sb writes rt_m[7:0] into byte lane aluout_m[1:0]; the other three bytes are preserved.
  - Merging is done with a per-byte write enable at posedge.
- Load: the word is read combinationally from the current memory contents.
  - lw returns the whole word.
  - lh/lhu select the halfword by aluout_m[1]; lb/lbu select the byte lane by aluout_m[1:0].
  - lh/lb sign-extend to 32 bits; lhu/lbu zero-extend.
- Misalignment conditions:
  - lw/sw with aluout_m[1:0]≠0.
  - lh/lhu/sh with aluout_m[0]=1.
  - Byte accesses are never misaligned.
- On misalignment: the store is suppressed (memory unchanged), a load returns dmout_w=0, and misalign_w=1. There is no other side effect.
- Non-memory instructions: no memory write, dmout_w=0, misalign_w=0.
- A word index at the top of memory, 2^DEPTH_LOG2−1, is a valid access.
- The M→W register loads every non-reset posedge with no stall or flush input. A bubble is represented by ir_m=0 (sll $0,$0,0), a non-memory instruction.

## Timing
- Reset (reset=1 at posedge):
  - ir_w, aluout_w, dmout_w, pc4_w and pc8_w become 0, and misalign_w becomes 0.
  - Every memory word is cleared to 0 in that same cycle.
  - Any store presented during reset is discarded.
  - Reset asserted mid-operation overrides the in-flight store.
- Store latency: the write lands at the posedge that ends the cycle the store occupies M. A load in the next M cycle sees the new data.
- Load latency: dmout_w is valid one cycle after the load is in M, that is, when the load is in W.
- Read-during-write: load and store are never in M in the same cycle, so no same-cycle conflict exists. A load directly following a store to the same word returns the post-store value.
- Outputs change only at posedge clk and are never combinational from the inputs.

## Test plan
- Reset clears memory: write sw 0x12345678 to address 0x10, then assert reset for one cycle, then lw 0x10 → dmout_w=0x00000000; all outputs 0 during and after reset.
- Byte merge:
  - Stimulus: sw 0xAABBCCDD to address 0x20, then sb rt=0x11 to 0x21, then sh rt=0x2233 to 0x22, then lw 0x20.
  - Required: dmout_w=0x2233_11DD.
- Extension with word 0x20 holding 0x8081F0FF:
  - lb 0x20 → 0xFFFFFFFF; lbu 0x21 → 0x000000F0.
  - lh 0x22 → 0xFFFF8081; lhu 0x22 → 0x00008081.
- Misalignment:
  - Stimulus: sw 0xDEADBEEF to 0x32, then lw 0x30, then lh 0x31.
  - Required: the store writes nothing and misalign_w=1; lw 0x30 → 0; lh 0x31 → dmout_w=0 and misalign_w=1.
- Wrap and top word with DEPTH_LOG2=10:
  - sw 0xCAFEF00D to 0x00000FFC, then lw 0x00001FFC → 0xCAFEF00D.
  - lw 0x00000FFC → 0xCAFEF00D.
- Pass-through: ir_m=0x00851020 (add), aluout_m=0x7, pc4_m=0x3004, pc8_m=0x3008 → next cycle ir_w=0x00851020, aluout_w=0x7, pc4_w=0x3004, pc8_w=0x3008, dmout_w=0, misalign_w=0; memory unchanged.
